sort_seq_ctrl: RTL and testbench
================================

SORT_SEQ_CTRL -- requirements
Module: sort_seq_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM, 16, maximum elements per batch.
- CNTW, 5, width of the index counter bus; must hold max(NUM-1, LAT).
- LAT, 3, sorting-network latency in cycles, 0 allowed.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- i_clk  in  1  clock.
- i_rst_n  in  1  async reset, active-low.
- i_start  in  1  begin batch; sampled in IDLE only.
- i_len  in  CNTW  batch length.
- i_desc  in  1  drain order: 0 ascending, 1 descending; latched with i_start.
- i_abort  in  1  synchronous abort.
- i_in_valid  in  1  load-side element valid.
- o_in_ready  out  1  load-side ready.
- o_load_we  out  1  write strobe to network input register.
- o_load_idx  out  CNTW  write slot.
- o_out_valid  out  1  drain-side valid.
- i_out_ready  in  1  drain-side ready.
- o_out_idx  out  CNTW  slot being drained.
- o_done  out  1  one-cycle batch-complete pulse.
- o_err  out  1  one-cycle bad-length pulse.
- o_cnt_init  out  CNTW  external counter init value.
- o_cnt_rst  out  1  external counter sync reload.
- o_cnt_en  out  1  external counter enable.
- o_cnt_count  out  1  external counter step.
- o_cnt_updown  out  1  external counter direction: 0 up, 1 down.
- i_cnt_dat  in  CNTW  external counter value.
REQ-003 Clock SHALL be i_clk; reset SHALL be i_rst_n, asynchronous, active-low.

Function
REQ-004 Block SHALL sequence one external up/down counter (reload has priority over step; value updates one cycle after controls) through states IDLE, LOAD, WAIT, DRAIN.
REQ-005 o_cnt_* controls SHALL be combinational from state and handshakes; all other control outputs SHALL be decoded from state and i_cnt_dat.
REQ-006 IDLE, i_start=1 with 1<=i_len<=NUM: latch i_len, i_desc; drive o_cnt_rst=1 with o_cnt_init=0; go to LOAD.
REQ-007 IDLE, i_start=1 with i_len=0 or i_len>NUM: pulse o_err for 1 cycle; stay IDLE.
REQ-008 LOAD: o_in_ready=1 and o_load_idx=i_cnt_dat.
- On i_in_valid&o_in_ready: o_load_we=1; count up (en=1, count=1, updown=0).
REQ-009 LOAD, accepted beat with i_cnt_dat==len-1:
- LAT>0: reload init=LAT; go to WAIT.
- LAT=0: reload init=(desc ? len-1 : 0); go to DRAIN.
REQ-010 WAIT: count down each cycle; when i_cnt_dat==1, reload init=(desc ? len-1 : 0) and go to DRAIN; WAIT SHALL last exactly LAT cycles.
REQ-011 DRAIN: o_out_valid=1 and o_out_idx=i_cnt_dat.
- On handshake: step with updown=desc.
- Output SHALL hold stable while i_out_ready=0.
REQ-012 DRAIN, handshake at the end index (desc ? 0 : len-1): pulse o_done for 1 cycle; go to IDLE; no counter wrap SHALL occur.
REQ-013 i_start outside IDLE SHALL be ignored.
REQ-014 i_abort=1 in any state SHALL force IDLE next cycle.
- o_done SHALL NOT pulse.
- Abort SHALL take priority over a same-cycle handshake or i_start.
REQ-015 o_in_ready, o_load_we, o_out_valid SHALL be 0 outside LOAD/DRAIN.
REQ-016 len=1 SHALL give one load beat and one drain beat, for either i_desc value.

Reset
REQ-017 On i_rst_n=0:
- State SHALL be IDLE; latched len SHALL be 0; latched desc SHALL be 0.
- o_cnt_init=0; all control, strobe and pulse outputs=0.
REQ-018 Reset mid-batch SHALL discard the batch without o_done; the first cycle after release SHALL accept i_start.

Verification
REQ-019 LAT=3, len=4, desc=0, in_valid always 1, out_ready always 1:
- load_idx 0,1,2,3; 3 WAIT cycles; out_idx 0,1,2,3; o_done on the last drain beat.
REQ-020 len=4, desc=1, out_ready toggling 1,0:
- out_idx 3,2,1,0, each held during ready=0; o_done once.
REQ-021 i_len=0, then i_len=17 with NUM=16:
- o_err pulses each time; no state change; o_in_ready stays 0.
REQ-022 LAT=0, len=1:
- one load beat, DRAIN next cycle, out_idx=0, o_done.
REQ-023 i_abort during DRAIN at idx 2, and i_rst_n low during LOAD:
- IDLE next cycle; no o_done; subsequent len=2 batch completes normally.
REQ-024 in_valid gaps in LOAD:
- load_idx advances only on handshakes; load_we count equals len.

Source files
------------

// File: rtl/sort_seq_ctrl.sv
// sort_seq_ctrl
//
// Sequences one external up/down counter through a sorting-network batch:
// loads up to NUM elements into the network input register, waits LAT cycles
// for the network to settle, then drains the sorted slots in ascending or
// descending index order.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start, i_len      begin a batch of i_len elements (sampled in IDLE only)
//   i_desc              drain order: 0 ascending, 1 descending
//   i_abort             synchronous abort back to IDLE
//   i_in_valid          load-side element valid
//   o_in_ready          load-side ready
//   o_load_we           write strobe to the network input register
//   o_load_idx          slot written by o_load_we
//   o_out_valid         drain-side valid
//   i_out_ready         drain-side ready
//   o_out_idx           slot being drained
//   o_done              one-cycle batch-complete pulse
//   o_err               one-cycle bad-length pulse
//   o_cnt_init          external counter reload value
//   o_cnt_rst           external counter synchronous reload
//   o_cnt_en            external counter enable
//   o_cnt_count         external counter step
//   o_cnt_updown        external counter direction: 0 up, 1 down
//   i_cnt_dat           external counter value
//
// The counter value updates one cycle after its controls, reload wins over
// step. Every index output is simply the counter value decoded by state.

module sort_seq_ctrl #(
  parameter int NUM  = 16,
  parameter int CNTW = 5,
  parameter int LAT  = 3
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [CNTW-1:0] i_len,
  input  logic            i_desc,
  input  logic            i_abort,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  output logic            o_load_we,
  output logic [CNTW-1:0] o_load_idx,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [CNTW-1:0] o_out_idx,
  output logic            o_done,
  output logic            o_err,
  output logic [CNTW-1:0] o_cnt_init,
  output logic            o_cnt_rst,
  output logic            o_cnt_en,
  output logic            o_cnt_count,
  output logic            o_cnt_updown,
  input  logic [CNTW-1:0] i_cnt_dat
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // One extra bit so NUM == 2**CNTW still compares correctly.
  localparam logic [CNTW:0]   NUM_EXT = (CNTW+1)'(NUM);
  localparam logic [CNTW-1:0] LAT_C   = CNTW'(LAT);
  localparam logic [CNTW-1:0] ONE_C   = CNTW'(1);

  state_t          state_q;
  state_t          state_d;
  logic [CNTW-1:0] len_q;
  logic            desc_q;
  logic            err_q;

  logic            len_ok;
  logic            start_ok;
  logic            start_bad;
  logic [CNTW-1:0] len_m1;
  logic [CNTW-1:0] drain_init;
  logic [CNTW-1:0] drain_end;

  assign len_ok    = (i_len != '0) && ({1'b0, i_len} <= NUM_EXT);
  assign start_ok  = (state_q == S_IDLE) && i_start && len_ok && !i_abort;
  assign start_bad = (state_q == S_IDLE) && i_start && !len_ok && !i_abort;

  assign len_m1     = len_q - ONE_C;
  assign drain_init = desc_q ? len_m1 : '0;
  assign drain_end  = desc_q ? '0 : len_m1;

  // State register plus the batch parameters captured at start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      desc_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= start_bad;
      if (start_ok) begin
        len_q  <= i_len;
        desc_q <= i_desc;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d      = state_q;
    o_in_ready   = 1'b0;
    o_load_we    = 1'b0;
    o_load_idx   = '0;
    o_out_valid  = 1'b0;
    o_out_idx    = '0;
    o_done       = 1'b0;
    o_cnt_init   = '0;
    o_cnt_rst    = 1'b0;
    o_cnt_en     = 1'b0;
    o_cnt_count  = 1'b0;
    o_cnt_updown = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          o_cnt_rst  = 1'b1;
          o_cnt_init = '0;
          state_d    = S_LOAD;
        end
      end

      S_LOAD: begin
        o_in_ready = 1'b1;
        o_load_idx = i_cnt_dat;
        if (i_in_valid && !i_abort) begin
          o_load_we   = 1'b1;
          o_cnt_en    = 1'b1;
          o_cnt_count = 1'b1;
          if (i_cnt_dat == len_m1) begin
            // Reload overrides the step issued above.
            o_cnt_rst = 1'b1;
            if (LAT > 0) begin
              o_cnt_init = LAT_C;
              state_d    = S_WAIT;
            end else begin
              o_cnt_init = drain_init;
              state_d    = S_DRAIN;
            end
          end
        end
      end

      S_WAIT: begin
        // Counter enters at LAT and leaves at 1, giving exactly LAT cycles.
        if (!i_abort) begin
          o_cnt_en     = 1'b1;
          o_cnt_count  = 1'b1;
          o_cnt_updown = 1'b1;
          if (i_cnt_dat == ONE_C) begin
            o_cnt_rst  = 1'b1;
            o_cnt_init = drain_init;
            state_d    = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        o_out_valid = 1'b1;
        o_out_idx   = i_cnt_dat;
        if (i_out_ready && !i_abort) begin
          if (i_cnt_dat == drain_end) begin
            // No step on the final beat so the counter never wraps.
            o_done  = 1'b1;
            state_d = S_IDLE;
          end else begin
            o_cnt_en     = 1'b1;
            o_cnt_count  = 1'b1;
            o_cnt_updown = desc_q;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (i_abort) begin
      state_d = S_IDLE;
    end
  end

  assign o_err = err_q;

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// tb_sort_seq_ctrl
//
// Directed bench for sort_seq_ctrl. Two instances share clock and reset:
// u_dut with LAT=3 and u_dut0 with LAT=0. Each has a behavioural model of
// the external up/down counter (reload before step, one-cycle update).
// Inputs change on the falling edge; outputs are sampled 1 ns later.

module tb_sort_seq_ctrl;

  localparam int NUM  = 16;
  localparam int CNTW = 5;
  localparam int LAT  = 3;

  logic            clk;
  logic            rst_n;

  logic            start, desc, abort, in_valid, out_ready;
  logic [CNTW-1:0] len;
  logic            in_ready, load_we, out_valid, done, err;
  logic [CNTW-1:0] load_idx, out_idx, cnt_init, cnt_dat;
  logic            cnt_rst, cnt_en, cnt_count, cnt_updown;

  logic            z_start, z_desc, z_abort, z_in_valid, z_out_ready;
  logic [CNTW-1:0] z_len;
  logic            z_in_ready, z_load_we, z_out_valid, z_done, z_err;
  logic [CNTW-1:0] z_load_idx, z_out_idx, z_cnt_init, z_cnt_dat;
  logic            z_cnt_rst, z_cnt_en, z_cnt_count, z_cnt_updown;

  int n_chk  = 0;
  int n_pass = 0;

  sort_seq_ctrl #(.NUM(NUM), .CNTW(CNTW), .LAT(LAT)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len),
    .i_desc(desc), .i_abort(abort), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .o_load_we(load_we), .o_load_idx(load_idx),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_idx(out_idx),
    .o_done(done), .o_err(err), .o_cnt_init(cnt_init), .o_cnt_rst(cnt_rst),
    .o_cnt_en(cnt_en), .o_cnt_count(cnt_count), .o_cnt_updown(cnt_updown),
    .i_cnt_dat(cnt_dat)
  );

  sort_seq_ctrl #(.NUM(NUM), .CNTW(CNTW), .LAT(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(z_start), .i_len(z_len),
    .i_desc(z_desc), .i_abort(z_abort), .i_in_valid(z_in_valid),
    .o_in_ready(z_in_ready), .o_load_we(z_load_we), .o_load_idx(z_load_idx),
    .o_out_valid(z_out_valid), .i_out_ready(z_out_ready), .o_out_idx(z_out_idx),
    .o_done(z_done), .o_err(z_err), .o_cnt_init(z_cnt_init), .o_cnt_rst(z_cnt_rst),
    .o_cnt_en(z_cnt_en), .o_cnt_count(z_cnt_count), .o_cnt_updown(z_cnt_updown),
    .i_cnt_dat(z_cnt_dat)
  );

  // External counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt_dat <= '0;
    else if (cnt_rst)                cnt_dat <= cnt_init;
    else if (cnt_en && cnt_count)    cnt_dat <= cnt_updown ? cnt_dat - 1'b1 : cnt_dat + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      z_cnt_dat <= '0;
    else if (z_cnt_rst)              z_cnt_dat <= z_cnt_init;
    else if (z_cnt_en && z_cnt_count) z_cnt_dat <= z_cnt_updown ? z_cnt_dat - 1'b1 : z_cnt_dat + 1'b1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Runs one batch on u_dut. Entered and left on a falling edge.
  // gap_in inserts in_valid bubbles (and holds i_start high during LOAD),
  // gap_out toggles out_ready 1,0, abort_d >= 0 aborts at that drain beat.
  task automatic run_batch(input int n, input bit dsc, input bit gap_in,
                           input bit gap_out, input int abort_d);
    int k, d, cyc, we_cnt, exp_idx;
    start = 1'b1; len = CNTW'(n); desc = dsc; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("start_cnt_rst", int'(cnt_rst), 1);
    check("start_cnt_init", int'(cnt_init), 0);
    @(negedge clk);
    start = gap_in;
    desc  = ~dsc;
    k = 0; cyc = 0; we_cnt = 0;
    while (k < n && cyc < 100) begin
      in_valid = gap_in ? (cyc % 3 != 1) : 1'b1;
      #1;
      check("load_ready", int'(in_ready), 1);
      check("load_idx", int'(load_idx), k);
      check("load_we", int'(load_we), int'(in_valid));
      if (load_we) we_cnt++;
      if (in_valid) k++;
      cyc++;
      @(negedge clk);
    end
    check("load_timeout", cyc < 100 ? 1 : 0, 1);
    check("load_we_count", we_cnt, n);
    in_valid = 1'b0;
    start    = 1'b0;
    for (int w = 0; w < LAT; w++) begin
      #1;
      check("wait_out_valid", int'(out_valid), 0);
      check("wait_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    d = 0; cyc = 0;
    while (d < n && cyc < 100) begin
      out_ready = gap_out ? (cyc % 2 == 0) : 1'b1;
      exp_idx   = dsc ? (n - 1 - d) : d;
      if (d == abort_d) begin
        abort = 1'b1;
        #1;
        check("abort_idx", int'(out_idx), exp_idx);
        check("abort_no_done", int'(done), 0);
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b0;
        #1;
        check("abort_idle_valid", int'(out_valid), 0);
        check("abort_idle_ready", int'(in_ready), 0);
        check("abort_idle_done", int'(done), 0);
        @(negedge clk);
        return;
      end
      #1;
      check("drain_valid", int'(out_valid), 1);
      check("drain_idx", int'(out_idx), exp_idx);
      check("drain_done", int'(done), (out_ready && d == n - 1) ? 1 : 0);
      if (out_ready) d++;
      cyc++;
      @(negedge clk);
    end
    check("drain_timeout", cyc < 100 ? 1 : 0, 1);
    out_ready = 1'b0;
    #1;
    check("end_idle_valid", int'(out_valid), 0);
    check("end_idle_done", int'(done), 0);
    @(negedge clk);
  endtask

  task automatic bad_len(input int n);
    start = 1'b1; len = CNTW'(n);
    #1;
    check("bad_no_reload", int'(cnt_rst), 0);
    check("bad_ready0", int'(in_ready), 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("bad_err_pulse", int'(err), 1);
    check("bad_still_idle", int'(in_ready), 0);
    @(negedge clk);
    #1;
    check("bad_err_clear", int'(err), 0);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; len = '0; desc = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    z_start = 1'b0; z_len = '0; z_desc = 1'b0; z_abort = 1'b0;
    z_in_valid = 1'b0; z_out_ready = 1'b0;

    @(negedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_cnt_init", int'(cnt_init), 0);
    check("rst_cnt_ctrl", int'({cnt_rst, cnt_en, cnt_count, cnt_updown}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic ascending batch, continuous handshakes.
    run_batch(4, 1'b0, 1'b0, 1'b0, -1);
    // Descending with out_ready toggling.
    run_batch(4, 1'b1, 1'b0, 1'b1, -1);
    // Bad lengths.
    bad_len(0);
    bad_len(17);
    // Load with bubbles and i_start held high, full-size batch.
    run_batch(NUM, 1'b0, 1'b1, 1'b0, -1);
    // Single-element batches in both orders.
    run_batch(1, 1'b0, 1'b0, 1'b0, -1);
    run_batch(1, 1'b1, 1'b0, 1'b1, -1);
    // Abort during drain at index 2, then a normal batch.
    run_batch(4, 1'b0, 1'b0, 1'b0, 2);
    run_batch(2, 1'b0, 1'b0, 1'b0, -1);

    // Reset mid-LOAD, then start on the first cycle after release.
    start = 1'b1; len = CNTW'(3); desc = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", int'(in_ready), 0);
    check("rst_mid_we", int'(load_we), 0);
    check("rst_mid_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    run_batch(2, 1'b1, 1'b0, 1'b0, -1);

    // LAT=0 instance, len=1 descending.
    z_start = 1'b1; z_len = CNTW'(1); z_desc = 1'b1;
    #1;
    check("z_start_rst", int'(z_cnt_rst), 1);
    @(negedge clk);
    z_start = 1'b0; z_in_valid = 1'b1; z_out_ready = 1'b0;
    #1;
    check("z_load_we", int'(z_load_we), 1);
    check("z_load_idx", int'(z_load_idx), 0);
    check("z_load_reload", int'(z_cnt_rst), 1);
    check("z_load_init", int'(z_cnt_init), 0);
    @(negedge clk);
    z_in_valid = 1'b0; z_out_ready = 1'b1;
    #1;
    check("z_drain_valid", int'(z_out_valid), 1);
    check("z_drain_idx", int'(z_out_idx), 0);
    check("z_drain_done", int'(z_done), 1);
    check("z_no_step", int'(z_cnt_en), 0);
    @(negedge clk);
    z_out_ready = 1'b0;
    #1;
    check("z_idle_valid", int'(z_out_valid), 0);
    check("z_idle_done", int'(z_done), 0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
